f11_vic: RTL and testbench



---
 rtl/f11_vic_pkg.sv | 19 +
 rtl/f11_vic_arb.sv | 30 +++
 rtl/f11_vic.sv | 95 +++++++++
 tb/tb_f11_vic.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/f11_vic_pkg.sv
// Shared types and constants for the f11_vic vectored interrupt controller.
package f11_vic_pkg;

  localparam int VIC_VW = 16;
  localparam int VIC_PW = 2;

  typedef enum logic [1:0] {
    VIC_IDLE = 2'd0,
    VIC_ARB  = 2'd1,
    VIC_ACK  = 2'd2,
    VIC_HOLD = 2'd3
  } vic_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/f11_vic_arb.sv
// Combinational priority encoder: highest priority among asserted requests wins, ties go to the lowest index.
module f11_vic_arb
  import f11_vic_pkg::*;
#(
  parameter int NIRQ = 8,
  parameter int IW = 3,
  parameter logic [NIRQ*VIC_PW-1:0] IVC_PRI = '0
) (
  input  logic [NIRQ-1:0] irq,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [VIC_PW-1:0] best;

  // Strict greater-than keeps the earliest (lowest) index on a tie.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (irq[i] && (!valid || IVC_PRI[i*VIC_PW +: VIC_PW] > best)) begin
        valid = 1'b1;
        idx   = IW'(i);
        best  = IVC_PRI[i*VIC_PW +: VIC_PW];
      end
    end
  end

endmodule

// File: rtl/f11_vic.sv
// Vectored interrupt controller: drives vm_virq priority lines and answers vector / fast-input strobes.
// Handshake: a strobe is taken in IDLE, answered by exactly one wbi_ack_o cycle, then the strobe must go low before another is accepted.
module f11_vic
  import f11_vic_pkg::*;
#(
  parameter int NIRQ = 8,
  parameter logic [NIRQ*VIC_VW-1:0] IVC_VEC = '0,
  parameter logic [NIRQ*VIC_PW-1:0] IVC_PRI = '0
) (
  input  logic              vm_clk_p,
  input  logic              vm_init,
  input  logic [NIRQ-1:0]   irq_i,
  output logic [NIRQ-1:0]   iack_o,
  output logic [7:4]        vm_virq,
  input  logic              wbi_stb_i,
  input  logic              wbi_una_i,
  output logic              wbi_ack_o,
  output logic [15:0]       wbi_dat_o,
  input  logic [15:0]       una_dat_i,
  output vic_state_e        state
);

  localparam int IW = idx_w(NIRQ);

  vic_state_e        state_nxt;
  logic [IW-1:0]     win_idx;
  logic              win_valid;
  logic [IW-1:0]     lat_idx;
  logic [VIC_VW-1:0] lat_dat;
  logic              lat_una;
  logic [3:0]        virq_nxt;

  f11_vic_arb #(
    .NIRQ    (NIRQ),
    .IW      (IW),
    .IVC_PRI (IVC_PRI)
  ) u_arb (
    .irq   (irq_i),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    virq_nxt = '0;
    for (int i = 0; i < NIRQ; i++) begin
      virq_nxt[IVC_PRI[i*VIC_PW +: VIC_PW]] = virq_nxt[IVC_PRI[i*VIC_PW +: VIC_PW]] | irq_i[i];
    end
  end

  // An empty ARB goes to HOLD without ack; the CPU bus timer ends that cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      VIC_IDLE: if (wbi_stb_i) state_nxt = wbi_una_i ? VIC_ACK : VIC_ARB;
      VIC_ARB: begin
        if (!wbi_stb_i)      state_nxt = VIC_IDLE;
        else if (!win_valid) state_nxt = VIC_HOLD;
        else                 state_nxt = VIC_ACK;
      end
      VIC_ACK:  state_nxt = VIC_HOLD;
      VIC_HOLD: if (!wbi_stb_i) state_nxt = VIC_IDLE;
      default:  state_nxt = VIC_IDLE;
    endcase
  end

  always_ff @(posedge vm_clk_p or posedge vm_init) begin
    if (vm_init) begin
      state   <= VIC_IDLE;
      vm_virq <= '0;
      lat_idx <= '0;
      lat_dat <= '0;
      lat_una <= 1'b0;
    end else begin
      state   <= state_nxt;
      vm_virq <= virq_nxt;
      if (state == VIC_IDLE && wbi_stb_i && wbi_una_i) begin
        lat_dat <= una_dat_i;
        lat_una <= 1'b1;
      end else if (state == VIC_ARB && wbi_stb_i && win_valid) begin
        lat_dat <= IVC_VEC[int'(win_idx)*VIC_VW +: VIC_VW];
        lat_idx <= win_idx;
        lat_una <= 1'b0;
      end
    end
  end

  // Outputs decode from state so an asynchronous reset clears them at once.
  always_comb begin
    wbi_ack_o = (state == VIC_ACK);
    wbi_dat_o = (state == VIC_ACK) ? lat_dat : '0;
    iack_o    = '0;
    if (state == VIC_ACK && !lat_una) iack_o[lat_idx] = 1'b1;
  end

endmodule

// File: tb/tb_f11_vic.sv
// Directed bench for f11_vic: reset, vector/fast-input cycles, arbitration, passive release, withdrawal.
module tb_f11_vic;
  import f11_vic_pkg::*;

  localparam int NIRQ = 8;
  // Priorities ch7..ch0 = 0,3,3,0,2,0,1,0
  localparam logic [NIRQ*VIC_PW-1:0] PRI = 16'h3C84;
  localparam logic [NIRQ*VIC_VW-1:0] VEC = {16'o134, 16'o130, 16'o124, 16'o120,
                                            16'o060, 16'o110, 16'o104, 16'o100};

  logic             clk;
  logic             vm_init;
  logic [NIRQ-1:0]  irq_i;
  logic [NIRQ-1:0]  iack_o;
  logic [7:4]       vm_virq;
  logic             wbi_stb_i;
  logic             wbi_una_i;
  logic             wbi_ack_o;
  logic [15:0]      wbi_dat_o;
  logic [15:0]      una_dat_i;
  vic_state_e       state;

  int n_checks = 0;
  int n_errors = 0;

  f11_vic #(
    .NIRQ    (NIRQ),
    .IVC_VEC (VEC),
    .IVC_PRI (PRI)
  ) dut (
    .vm_clk_p  (clk),
    .vm_init   (vm_init),
    .irq_i     (irq_i),
    .iack_o    (iack_o),
    .vm_virq   (vm_virq),
    .wbi_stb_i (wbi_stb_i),
    .wbi_una_i (wbi_una_i),
    .wbi_ack_o (wbi_ack_o),
    .wbi_dat_o (wbi_dat_o),
    .una_dat_i (una_dat_i),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise the strobe, wait (bounded) for the ack, check data/iack/latency, then close the cycle.
  task automatic vec_cycle(input string tag, input logic [7:0] irq, input logic una,
                           input logic [15:0] udat, input logic [15:0] exp_dat,
                           input logic [7:0] exp_iack, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    irq_i = irq; wbi_una_i = una; una_dat_i = udat; wbi_stb_i = 1'b1;
    lat = 0; seen = 1'b0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(negedge clk);
      lat = n;
      if (wbi_ack_o) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dat"}, 32'(wbi_dat_o), 32'(exp_dat));
    check({tag, "_iack"}, 32'(iack_o), 32'(exp_iack));
    @(negedge clk);
    check({tag, "_ack_width"}, 32'(wbi_ack_o), 32'd0);
    check({tag, "_iack_width"}, 32'(iack_o), 32'd0);
    wbi_stb_i = 1'b0; wbi_una_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_idle"}, 32'(state), 32'(VIC_IDLE));
  endtask

  initial begin
    int acks;
    bit seen;
    vm_init = 1'b1; irq_i = '0; wbi_stb_i = 1'b0; wbi_una_i = 1'b0; una_dat_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(wbi_ack_o), 32'd0);
    check("rst_dat", 32'(wbi_dat_o), 32'd0);
    check("rst_iack", 32'(iack_o), 32'd0);
    check("rst_virq", 32'(vm_virq), 32'd0);
    check("rst_state", 32'(state), 32'(VIC_IDLE));
    vm_init = 1'b0;

    // virq latency: one clock
    @(negedge clk);
    irq_i = 8'h08;
    #1 check("virq_before_edge", 32'(vm_virq), 32'h0);
    @(negedge clk);
    check("virq_single", 32'(vm_virq), 32'b0100);

    vec_cycle("single", 8'h08, 1'b0, 16'h0, 16'o060, 8'h08, 2);

    vec_cycle("arb", 8'h62, 1'b0, 16'h0, 16'o124, 8'h20, 2);
    check("virq_arb", 32'(vm_virq), 32'b1010);

    vec_cycle("fast", 8'h00, 1'b1, 16'o173004, 16'o173004, 8'h00, 1);

    // passive release: no request, strobe held 64 cycles
    @(negedge clk);
    irq_i = '0; wbi_stb_i = 1'b1;
    acks = 0;
    repeat (64) begin
      @(negedge clk);
      if (wbi_ack_o || iack_o != '0) acks++;
    end
    check("passive_no_ack", 32'(acks), 32'd0);
    check("passive_hold", 32'(state), 32'(VIC_HOLD));
    wbi_stb_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("passive_idle", 32'(state), 32'(VIC_IDLE));
    vec_cycle("after_release", 8'h01, 1'b0, 16'h0, 16'o100, 8'h01, 2);

    // strobe withdrawn during ARB: no ack, back to IDLE
    @(negedge clk);
    irq_i = 8'h10; wbi_stb_i = 1'b1;
    @(negedge clk);
    check("abort_in_arb", 32'(state), 32'(VIC_ARB));
    wbi_stb_i = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (wbi_ack_o) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_idle", 32'(state), 32'(VIC_IDLE));

    // request arriving while in ARB still competes
    irq_i = '0; wbi_stb_i = 1'b1;
    @(negedge clk);
    irq_i = 8'h80;
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      @(negedge clk);
      if (wbi_ack_o) seen = 1'b1;
    end
    check("late_ack_seen", 32'(seen), 32'd1);
    check("late_dat", 32'(wbi_dat_o), 32'(16'o134));
    check("late_iack", 32'(iack_o), 32'h80);
    @(negedge clk);
    wbi_stb_i = 1'b0; irq_i = '0;
    @(negedge clk);
    @(negedge clk);

    // withdrawal in ACK cycle, then strobe held 10 cycles
    irq_i = 8'h04; wbi_stb_i = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      @(negedge clk);
      if (wbi_ack_o) seen = 1'b1;
    end
    irq_i = '0;
    #1;
    check("wd_ack_seen", 32'(seen), 32'd1);
    check("wd_dat", 32'(wbi_dat_o), 32'(16'o110));
    check("wd_iack", 32'(iack_o), 32'h04);
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (wbi_ack_o || iack_o != '0) acks++;
    end
    check("hold_no_second_ack", 32'(acks), 32'd0);
    wbi_stb_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset asserted in the ACK cycle
    irq_i = 8'h22; wbi_stb_i = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      @(negedge clk);
      if (wbi_ack_o) seen = 1'b1;
    end
    check("mid_ack_seen", 32'(seen), 32'd1);
    check("mid_virq_pre", 32'(vm_virq), 32'b1010);
    vm_init = 1'b1;
    #1;
    check("mid_rst_ack", 32'(wbi_ack_o), 32'd0);
    check("mid_rst_iack", 32'(iack_o), 32'd0);
    check("mid_rst_virq", 32'(vm_virq), 32'd0);
    check("mid_rst_dat", 32'(wbi_dat_o), 32'd0);
    wbi_stb_i = 1'b0; irq_i = '0;
    @(negedge clk);
    vm_init = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 32'(state), 32'(VIC_IDLE));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
